// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one shared multiplier walks TAPS coefficients per
// accepted sample, then scales, saturates and strobes the result.
module fir_mac_sequencer #(
    parameter int TAPS  = 16,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int OW    = 16,
    parameter int SHIFT = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic signed [DW-1:0]    sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic signed [CW-1:0]    coef_data,
    input  logic                    overrun_clr,
    output logic signed [OW-1:0]    fir_out,
    output logic                    fir_valid,
    output logic                    busy,
    output logic                    overrun
);
    localparam int AW   = $clog2(TAPS);
    localparam int PW   = DW + CW;
    localparam int ACCW = PW + AW;
    localparam int EW   = ACCW + OW;
    localparam logic signed [EW-1:0] OUT_MAX = EW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] OUT_MIN = -OUT_MAX - EW'(1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state, state_nxt;
    logic [AW-1:0]          wr_ptr, k, rd_idx;
    logic signed [ACCW-1:0] acc, scaled;
    logic signed [EW-1:0]   scaled_ext;
    logic signed [PW-1:0]   product;
    logic signed [OW-1:0]   sat_val;
    logic                   accept;
    logic signed [DW-1:0]   delay [TAPS];
    logic signed [CW-1:0]   coef  [TAPS];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        sample_ready = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                sample_ready = 1'b1;
                accept       = sample_valid;
                if (sample_valid) state_nxt = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (k == AW'(TAPS - 1)) state_nxt = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tap k pairs with the sample k positions older than the newest one (modulo TAPS).
    always_comb begin
        rd_idx     = wr_ptr - k;
        product    = coef[k] * delay[rd_idx];
        scaled     = acc >>> SHIFT;
        scaled_ext = EW'(scaled);
        if (scaled_ext > OUT_MAX)      sat_val = OW'(OUT_MAX);
        else if (scaled_ext < OUT_MIN) sat_val = OW'(OUT_MIN);
        else                           sat_val = OW'(scaled_ext);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            k         <= '0;
            acc       <= '0;
            fir_out   <= '0;
            fir_valid <= 1'b0;
            overrun   <= 1'b0;
            // NOTE: both memories are cleared on reset so stale pre-reset samples never leak
            // into the first results; this keeps them in flops rather than RAM.
            for (int i = 0; i < TAPS; i++) begin
                delay[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            state     <= state_nxt;
            fir_valid <= 1'b0;

            if (sample_valid && !sample_ready) overrun <= 1'b1;
            else if (overrun_clr)              overrun <= 1'b0;

            if (coef_we && state == IDLE) coef[coef_addr] <= coef_data;

            case (state)
                IDLE: begin
                    if (accept) begin
                        delay[wr_ptr] <= sample_in;
                        acc           <= '0;
                        k             <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(product);
                    k   <= k + 1'b1;
                end
                OUT: begin
                    fir_out   <= sat_val;
                    fir_valid <= 1'b1;
                    wr_ptr    <= wr_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: impulse table, overrun, coefficient gating,
// back-to-back, full scale/saturation (SHIFT=4 and SHIFT=0 instances) and reset abort.
module tb_fir_mac_sequencer;
    localparam int TAPS = 16;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic signed [7:0]  sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               coef_we = 1'b0;
    logic [3:0]         coef_addr = '0;
    logic signed [7:0]  coef_data = '0;
    logic               overrun_clr = 1'b0;

    logic               sample_ready, fir_valid, busy, overrun;
    logic signed [15:0] fir_out;
    logic               sample_ready_s0, fir_valid_s0, busy_s0, overrun_s0;
    logic signed [15:0] fir_out_s0;

    fir_mac_sequencer dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .overrun_clr(overrun_clr),
        .fir_out(fir_out), .fir_valid(fir_valid), .busy(busy), .overrun(overrun)
    );

    fir_mac_sequencer #(.SHIFT(0)) dut_s0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready_s0), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .overrun_clr(overrun_clr),
        .fir_out(fir_out_s0), .fir_valid(fir_valid_s0), .busy(busy_s0), .overrun(overrun_s0)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic signed [7:0] sample;
        int                exp_out;
        int                exp_s0;
    } vec_t;
    vec_t vecs [17];

    // Reference model: m_hist[0] is the newest accepted sample.
    int     m_coef [TAPS];
    int     m_hist [TAPS];
    longint exp0, exp1;
    int     acc_cyc;

    // Back-to-back bookkeeping.
    longint b2b_exp [$];
    int     prev_acc, n_acc, n_res, bad_gap, vseen;
    bit     acc_now;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic longint model_out(input int shift);
        longint acc = 0;
        for (int i = 0; i < TAPS; i++) acc += longint'(m_coef[i]) * longint'(m_hist[i]);
        acc = acc >>> shift;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic model_push(input int s);
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = s;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = addr[3:0];
        coef_data = data[7:0];
        tick();
        coef_we = 1'b0;
        m_coef[addr] = data;
    endtask

    task automatic accept_sample(input int s, input bit we = 1'b0,
                                 input int addr = 0, input int data = 0);
        int n = 0;
        while (!sample_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", sample_ready, 1);
        sample_in    = s[7:0];
        sample_valid = 1'b1;
        coef_we      = we;
        coef_addr    = addr[3:0];
        coef_data    = data[7:0];
        tick();
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        if (we) m_coef[addr] = data;
        model_push(s);
        exp0    = model_out(4);
        exp1    = model_out(0);
        acc_cyc = cyc;
    endtask

    task automatic wait_result(input string tag, input longint e0, input longint e1);
        int n = 0;
        while (!fir_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, cyc - acc_cyc, 17);
        check({tag, "_out"}, fir_out, e0);
        check({tag, "_out_s0"}, fir_out_s0, e1);
        check({tag, "_ready"}, sample_ready, 1);
        tick();
        check({tag, "_pulse_len"}, fir_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
        vecs[0] = '{8'sd16, 1, 16};
        for (int i = 1; i < 16; i++) vecs[i] = '{8'sd0, i + 1, 16 * (i + 1)};
        vecs[16] = '{8'sd0, 0, 0};

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_fir_out", fir_out, 0);
        check("rst_fir_valid", fir_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_ready", sample_ready, 1);
        sys_rst_n = 1'b1;
        tick();
        check("post_rst_ready", sample_ready, 1);

        // Impulse response with coef[k] = k+1
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        for (int i = 0; i < 17; i++) begin
            accept_sample(vecs[i].sample);
            wait_result($sformatf("impulse%0d", i), vecs[i].exp_out, vecs[i].exp_s0);
        end
        check("impulse_no_overrun", overrun, 0);

        // Overrun mid-MAC; set beats a coincident clear
        accept_sample(5);
        repeat (5) tick();
        check("busy_mid_mac", busy, 1);
        check("ready_mid_mac", sample_ready, 0);
        sample_in = -8'sd77;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("overrun_set", overrun, 1);
        sample_valid = 1'b1;
        overrun_clr  = 1'b1;
        tick();
        sample_valid = 1'b0;
        overrun_clr  = 1'b0;
        check("overrun_set_wins", overrun, 1);
        wait_result("ovr", exp0, exp1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("overrun_clr", overrun, 0);
        accept_sample(3);
        wait_result("ovr_next", exp0, exp1);

        // Coefficient writes ignored while busy, honoured in IDLE and on accept
        accept_sample(10);
        repeat (3) tick();
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'sd99;
        tick();
        coef_we = 1'b0;
        wait_result("gate_busy", exp0, exp1);
        accept_sample(4);
        wait_result("gate_next", exp0, exp1);
        write_coef(0, 99);
        accept_sample(4);
        wait_result("gate_idle", exp0, exp1);
        accept_sample(7, 1'b1, 0, -50);
        wait_result("coef_coincide", exp0, exp1);

        // Back-to-back with sample_valid held high: 18 accepts, wr_ptr wraps
        prev_acc = -1; n_acc = 0; n_res = 0; bad_gap = 0;
        sample_in = 8'sd11;
        sample_valid = 1'b1;
        for (int c = 0; c < 400 && n_res < 18; c++) begin
            acc_now = sample_ready && sample_valid;
            if (acc_now) begin
                model_push(sample_in);
                b2b_exp.push_back(model_out(4));
                if (prev_acc >= 0 && cyc - prev_acc != 18) bad_gap++;
                prev_acc = cyc;
                n_acc++;
            end
            tick();
            if (acc_now) begin
                sample_in = 8'(n_acc * 37 + 11);
                if (n_acc == 18) sample_valid = 1'b0;
            end
            if (fir_valid) begin
                check($sformatf("b2b_out%0d", n_res), fir_out, b2b_exp.pop_front());
                n_res++;
            end
        end
        check("b2b_accepts", n_acc, 18);
        check("b2b_results", n_res, 18);
        check("b2b_spacing_errors", bad_gap, 0);
        check("b2b_overrun", overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;

        // Full scale and saturation
        for (int i = 0; i < TAPS; i++) write_coef(i, 127);
        for (int i = 0; i < TAPS; i++) begin
            accept_sample(127);
            wait_result($sformatf("pos%0d", i), exp0, exp1);
        end
        check("full_pos", fir_out, 16129);
        check("sat_pos", fir_out_s0, 32767);
        for (int i = 0; i < TAPS; i++) begin
            accept_sample(-128);
            wait_result($sformatf("neg%0d", i), exp0, exp1);
        end
        check("full_neg", fir_out, -16256);
        check("sat_neg", fir_out_s0, -32768);

        // Reset mid-MAC aborts the sample
        accept_sample(50);
        repeat (7) tick();
        sys_rst_n = 1'b0;
        #2;
        check("abort_ready", sample_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_fir_out", fir_out, 0);
        vseen = 0;
        repeat (2) begin
            tick();
            if (fir_valid) vseen++;
        end
        sys_rst_n = 1'b1;
        repeat (25) begin
            tick();
            if (fir_valid) vseen++;
        end
        check("abort_no_valid", vseen, 0);
        check("abort_fir_out_held", fir_out, 0);
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
        for (int i = 0; i < TAPS; i++) write_coef(i, 1);
        accept_sample(16);
        wait_result("post_abort_impulse", 1, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR controller: accepts one 8-bit signed sample per handshake, stores it in a circular delay line, and sequences TAPS multiply-accumulate steps through one shared multiplier. The result is scaled and saturated to a 16-bit output with a one-cycle valid strobe. It sits between the bit-to-sample front end (serial data_in at 100 kbps) and downstream `fir_out` consumers on the 50 MHz `sys_clk` domain. Coefficients are runtime-loadable through a simple write port.

## Interface
- TAPS, 16: number of taps and delay-line depth; power of two, ≥ 2.
- DW, 8: sample width, signed.
- CW, 8: coefficient width, signed.
- OW, 16: output width, signed.
- SHIFT, 4: arithmetic right shift applied to the accumulator before saturation.
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- sample_in  in  DW  input sample, signed.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  high only in IDLE; a sample is accepted on an edge where valid && ready.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  tap index k.
- coef_data  in  CW  coefficient value, signed.
- overrun_clr  in  1  clears overrun.
- fir_out  out  OW  last filter result, signed; holds between results.
- fir_valid  out  1  one-cycle pulse when fir_out updates.
- busy  out  1  high in MAC and OUT.
- overrun  out  1  sticky; a sample was offered while not ready.

## Operation
- States: IDLE, MAC, OUT.
- IDLE: sample_ready = 1. On accept:
  - write sample_in to delay[wr_ptr];
  - clear acc;
  - set k = 0;
  - go to MAC.
- MAC: one tap per cycle: acc += coef[k] * delay[(wr_ptr − k) mod TAPS]. k increments each cycle. Leave for OUT after k = TAPS−1.
- OUT:
  - fir_out ← sat_OW(acc >>> SHIFT);
  - fir_valid ← 1 for one cycle;
  - wr_ptr ← wr_ptr + 1, wrapping modulo TAPS;
  - go to IDLE.
- Arithmetic:
  - product is a signed DW+CW-bit value;
  - acc is signed, DW+CW+log2(TAPS) bits (20 by default), and cannot overflow;
  - the shift is arithmetic;
  - saturation clamps to [−2^(OW−1), 2^(OW−1)−1].
- Coefficient writes:
  - applied on the edge where coef_we = 1 and state = IDLE;
  - ignored when busy = 1 (no queuing);
  - a write coincident with a sample accept takes effect, and that accept's MAC uses the new value.
- Overrun: set on any edge with sample_valid = 1 and sample_ready = 0. The sample is dropped, and the computation in progress is unaffected. Cleared by overrun_clr. If set and clear coincide, set wins.
- Reset: asynchronous, and aborts any operation; no fir_valid is produced for the aborted sample. Reset values:
  - state = IDLE;
  - wr_ptr = 0, k = 0, acc = 0;
  - every delay-line entry = 0 and every coefficient = 0;
  - fir_out = 0, fir_valid = 0, busy = 0, overrun = 0;
  - sample_ready = 1, since it decodes IDLE.

## Timing
- Accept on edge E0. MAC accumulates on edges E1..E_TAPS. OUT registers fir_out and fir_valid on edge E_TAPS+1.
- fir_valid is high in the cycle following E_TAPS+1; sample_ready is high again in that same cycle.
- Latency from accept to fir_valid is TAPS+1 edges (17 by default). Minimum accept spacing is TAPS+2 cycles (18). At 50 MHz this far exceeds the sample-rate requirement.
- busy and sample_ready are decoded from the registered state, with no combinational path from inputs.
- fir_out changes only together with fir_valid.

## Test plan
- Impulse response (coef[k] = k+1):
  - stimulus: sample 16, then 16 zeros, each accepted as soon as ready;
  - fir_out sequence: 1, 2, …, 16, then 0;
  - each result has exactly one fir_valid pulse, 17 edges after its accept.
- Full scale (all coef = 127):
  - 16 samples of 127 → final fir_out = 16129;
  - 16 samples of −128 → final fir_out = −16256.
- Saturation (SHIFT = 0, all coef = 127): 16 samples of 127 → fir_out = 32767; 16 samples of −128 → fir_out = −32768.
- Overrun:
  - pulse sample_valid mid-MAC → overrun = 1 next cycle;
  - the current fir_out equals the no-overrun value, and the dropped sample never enters the delay line;
  - overrun_clr → overrun = 0.
- Coefficient gating: coef_we while busy leaves the coefficient unchanged, as seen in the next result. The same write in IDLE takes effect.
- Reset mid-MAC:
  - assert sys_rst_n low at E8 → no fir_valid, fir_out = 0, sample_ready = 1;
  - the next impulse with unit coefficients yields 0 contribution from pre-reset samples.
- Back-to-back: sample_valid held high → accepts exactly every 18 cycles, with wr_ptr wrapping after 16 samples.
